// File: rtl/ac97_frame_tx.sv
// ac97_frame_tx: serializes PCM samples and codec register writes into AC'97 output frames
module ac97_frame_tx #(
  parameter int INIT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] left_pcm,
  input  logic [19:0] right_pcm,
  input  logic        cmd_valid,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        cmd_ready,
  output logic        ready,
  output logic        ac97_sync,
  output logic        ac97_sdata_out
);
  localparam int CW = $clog2(INIT_CYCLES + 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t        state, state_d;
  logic [CW-1:0] cnt;
  logic [7:0]    pos;
  logic [95:0]   shift, frame;
  logic          pending, capture, accept;
  logic [6:0]    addr_q;
  logic [15:0]   data_q;
  always_comb begin
    accept  = cmd_valid & cmd_ready;
    capture = state == INIT ? cnt == CW'(INIT_CYCLES - 1) : pos == 8'd255;
    state_d = capture ? RUN : state;
    frame   = {1'b1, pending, pending, 2'b11, 11'b0,
               1'b0, pending ? addr_q : 7'b0, 12'b0,
               pending ? data_q : 16'b0, 4'b0,
               left_pcm, right_pcm};
  end
  // Only the first 96 frame bits carry data; the shifter backfills zeros for slots 5-12.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= INIT;
      cnt            <= '0;
      pos            <= '0;
      shift          <= '0;
      ready          <= 1'b0;
      ac97_sync      <= 1'b0;
      ac97_sdata_out <= 1'b0;
      cmd_ready      <= 1'b1;
      pending        <= 1'b0;
      addr_q         <= '0;
      data_q         <= '0;
    end else begin
      state          <= state_d;
      cnt            <= state == INIT ? cnt + CW'(1) : cnt;
      ready          <= capture;
      pos            <= capture ? 8'd0 : state == RUN ? pos + 8'd1 : pos;
      ac97_sync      <= capture | (state == RUN && pos < 8'd15);
      ac97_sdata_out <= capture ? frame[95] : state == RUN && shift[95];
      shift          <= capture ? {frame[94:0], 1'b0} : shift << 1;
      pending        <= accept | (pending & ~capture);
      cmd_ready      <= accept ? 1'b0 : (state == RUN && pos == 8'd0 && !pending) ? 1'b1 : cmd_ready;
      if (accept) begin
        addr_q <= cmd_addr;
        data_q <= cmd_data;
      end
    end
  end
endmodule

// File: tb/tb_ac97_frame_tx.sv
// tb_ac97_frame_tx: scoreboard bench for the AC'97 frame serializer
module tb_ac97_frame_tx;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] left_pcm = '0, right_pcm = '0;
  logic        cmd_valid = 1'b0;
  logic [6:0]  cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic        cmd_ready, ready, ac97_sync, ac97_sdata_out;
  int          n_tests = 0, n_fail = 0;
  int          mon_pos = -1;
  bit          collecting = 1'b0;
  logic [255:0] rx_d, rx_s;
  logic [255:0] rx_q[$], rxs_q[$], exp_q[$];
  localparam logic [255:0] SYNC_EXP = {16'hFFFF, 240'b0};

  ac97_frame_tx #(.INIT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .left_pcm(left_pcm), .right_pcm(right_pcm),
    .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .ready(ready), .ac97_sync(ac97_sync), .ac97_sdata_out(ac97_sdata_out)
  );

  always #5 clock = ~clock;

  // Frame monitor: bit p of a frame lands at rx_d[255-p]; full frames go to rx_q.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      collecting = 1'b0;
      mon_pos = -1;
    end else begin
      if (ready) begin
        collecting = 1'b1;
        mon_pos = 0;
      end else if (collecting) mon_pos++;
      if (collecting && mon_pos < 256) begin
        rx_d[255 - mon_pos] = ac97_sdata_out;
        rx_s[255 - mon_pos] = ac97_sync;
        if (mon_pos == 255) begin
          rx_q.push_back(rx_d);
          rxs_q.push_back(rx_s);
        end
      end
    end
  end

  function automatic logic [255:0] frm(input logic [15:0] tag, input logic [19:0] s1, s2, l, r);
    return {tag, s1, s2, l, r, 160'b0};
  endfunction

  task automatic sync_pos(input int p);
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (mon_pos == p) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL sync_pos timeout waiting for pos %0d, at %0d", p, mon_pos);
  endtask

  task automatic get_frame(output logic [255:0] d, s, output bit ok);
    ok = 1'b0;
    d = 'x;
    s = 'x;
    for (int i = 0; i < 1000 && !ok; i++) begin
      if (rx_q.size() > 0) begin
        d = rx_q.pop_front();
        s = rxs_q.pop_front();
        ok = 1'b1;
      end else @(negedge clock);
    end
  endtask

  task automatic clear_rx;
    rx_q.delete();
    rxs_q.delete();
  endtask

  task automatic test_reset;
    int first;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_tests++;
    if ({ready, ac97_sync, ac97_sdata_out, cmd_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_state got %b exp 0001", {ready, ac97_sync, ac97_sdata_out, cmd_ready});
    end
    reset = 1'b0;
    first = 0;
    for (int k = 1; k <= 300 && first == 0; k++) begin
      @(negedge clock);
      if (ready || ac97_sync || ac97_sdata_out) first = k;
    end
    n_tests++;
    if (first != 16 || ready !== 1'b1 || ac97_sync !== 1'b1) begin
      n_fail++;
      $display("FAIL init_len first activity at %0d ready=%b exp 16 ready=1", first, ready);
    end
    first = 0;
    for (int k = 1; k <= 300 && first == 0; k++) begin
      @(negedge clock);
      if (ready) first = k;
    end
    n_tests++;
    if (first != 256) begin
      n_fail++;
      $display("FAIL frame_period got %0d exp 256", first);
    end
  endtask

  task automatic test_pcm;
    logic [255:0] got, gsync, want;
    bit ok;
    sync_pos(100);
    clear_rx();
    exp_q.push_back(frm(16'h9800, 0, 0, 0, 0));
    left_pcm = 20'hA5A5A;
    right_pcm = 20'h12345;
    exp_q.push_back(frm(16'h9800, 0, 0, 20'hA5A5A, 20'h12345));
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      get_frame(got, gsync, ok);
      n_tests += 2;
      if (!ok || got !== want) begin n_fail++; $display("FAIL pcm_frame got %h exp %h", got, want); end
      if (gsync !== SYNC_EXP) begin n_fail++; $display("FAIL pcm_sync got %h exp %h", gsync, SYNC_EXP); end
    end
  endtask

  task automatic test_cmd;
    logic [255:0] got, gsync, want;
    bit ok;
    sync_pos(100);
    clear_rx();
    exp_q.push_back(frm(16'h9800, 0, 0, 20'hA5A5A, 20'h12345));
    n_tests++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_ready_idle got %b exp 1", cmd_ready); end
    cmd_valid = 1'b1;
    cmd_addr = 7'h02;
    cmd_data = 16'h0808;
    @(negedge clock);
    cmd_valid = 1'b0;
    n_tests++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL cmd_ready_after_accept got %b exp 0", cmd_ready); end
    exp_q.push_back(frm(16'hF800, 20'h02000, 20'h08080, 20'hA5A5A, 20'h12345));
    exp_q.push_back(frm(16'h9800, 0, 0, 20'hA5A5A, 20'h12345));
    sync_pos(0);
    n_tests++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL cmd_ready_pos0 got %b exp 0", cmd_ready); end
    sync_pos(1);
    n_tests++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_ready_pos1 got %b exp 1", cmd_ready); end
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      get_frame(got, gsync, ok);
      n_tests += 2;
      if (!ok || got !== want) begin n_fail++; $display("FAIL cmd_frame got %h exp %h", got, want); end
      if (gsync !== SYNC_EXP) begin n_fail++; $display("FAIL cmd_sync got %h exp %h", gsync, SYNC_EXP); end
    end
  endtask

  task automatic test_cmd_at_255;
    logic [255:0] got, gsync, want;
    bit ok;
    sync_pos(100);
    clear_rx();
    exp_q.push_back(frm(16'h9800, 0, 0, 20'hA5A5A, 20'h12345));
    sync_pos(255);
    cmd_valid = 1'b1;
    cmd_addr = 7'h15;
    cmd_data = 16'hBEEF;
    @(negedge clock);
    cmd_valid = 1'b0;
    n_tests++;
    if (cmd_ready !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd255_accept cmd_ready=%b ready=%b exp 0 1", cmd_ready, ready);
    end
    exp_q.push_back(frm(16'h9800, 0, 0, 20'hA5A5A, 20'h12345));
    exp_q.push_back(frm(16'hF800, 20'h15000, 20'hBEEF0, 20'hA5A5A, 20'h12345));
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      get_frame(got, gsync, ok);
      n_tests += 2;
      if (!ok || got !== want) begin n_fail++; $display("FAIL cmd255_frame got %h exp %h", got, want); end
      if (gsync !== SYNC_EXP) begin n_fail++; $display("FAIL cmd255_sync got %h exp %h", gsync, SYNC_EXP); end
    end
  endtask

  task automatic test_pcm_change;
    logic [255:0] got, gsync, want;
    bit ok;
    sync_pos(100);
    clear_rx();
    exp_q.push_back(frm(16'h9800, 0, 0, 20'hA5A5A, 20'h12345));
    sync_pos(1);
    left_pcm = 20'h5A5A5;
    exp_q.push_back(frm(16'h9800, 0, 0, 20'hA5A5A, 20'h12345));
    exp_q.push_back(frm(16'h9800, 0, 0, 20'h5A5A5, 20'h12345));
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      get_frame(got, gsync, ok);
      n_tests += 2;
      if (!ok || got !== want) begin n_fail++; $display("FAIL change_frame got %h exp %h", got, want); end
      if (gsync !== SYNC_EXP) begin n_fail++; $display("FAIL change_sync got %h exp %h", gsync, SYNC_EXP); end
    end
  endtask

  task automatic test_reset_mid;
    logic [255:0] got, gsync, want;
    bit ok;
    int first;
    sync_pos(20);
    cmd_valid = 1'b1;
    cmd_addr = 7'h7F;
    cmd_data = 16'hFFFF;
    @(negedge clock);
    cmd_valid = 1'b0;
    sync_pos(60);
    reset = 1'b1;
    @(negedge clock);
    n_tests++;
    if ({ready, ac97_sync, ac97_sdata_out, cmd_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL midreset_state got %b exp 0001", {ready, ac97_sync, ac97_sdata_out, cmd_ready});
    end
    reset = 1'b0;
    clear_rx();
    first = 0;
    for (int k = 1; k <= 300 && first == 0; k++) begin
      @(negedge clock);
      if (ready || ac97_sync || ac97_sdata_out) first = k;
    end
    n_tests++;
    if (first != 16 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_init first activity at %0d ready=%b exp 16 ready=1", first, ready);
    end
    exp_q.push_back(frm(16'h9800, 0, 0, 20'h5A5A5, 20'h12345));
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      get_frame(got, gsync, ok);
      n_tests += 2;
      if (!ok || got !== want) begin n_fail++; $display("FAIL midreset_frame got %h exp %h", got, want); end
      if (gsync !== SYNC_EXP) begin n_fail++; $display("FAIL midreset_sync got %h exp %h", gsync, SYNC_EXP); end
    end
  endtask

  initial begin
    test_reset();
    test_pcm();
    test_cmd();
    test_cmd_at_255();
    test_pcm_change();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
